trap_sequencer: RTL

- Sits between the pipeline's exception/interrupt/mret sources and the CSR unit.
- Picks one event by fixed priority and holds the front end while in-flight work drains.
- Sends exactly one single-cycle commit pulse to the CSR unit (trap_sources / is_mret), then one single-cycle pipeline flush.
- Guarantees that a trap and an mret never commit in the same cycle, and that no new event is taken mid-sequence.

---
 rtl/trap_sequencer.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/trap_sequencer.sv
// Trap/mret sequencer: picks one event, drains the pipe, then emits one commit pulse and one flush.
// Optional per-kind commit counters are compiled in with `define TRAP_SEQ_PERF_EN.
module trap_sequencer #(
  parameter int unsigned DRAIN_MAX = 8,
  parameter logic [31:0] IRQ_CAUSE = 32'h8000000B
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [3:0]  i_exc_valid,
  input  logic [31:0] i_exc_pc,
  input  logic        i_irq_pending,
  input  logic        i_is_mret,
  input  logic [31:0] i_current_pc,
  input  logic [1:0]  i_current_privilege,
  input  logic        i_pipe_busy,
  output logic        o_trap_valid,
  output logic [31:0] o_trap_cause,
  output logic [31:0] o_trap_instr_pc,
  output logic        o_mret_valid,
  output logic        o_stall,
  output logic        o_flush,
  output logic        o_drain_timeout
`ifdef TRAP_SEQ_PERF_EN
  ,
  output logic [15:0] o_exc_count,
  output logic [15:0] o_irq_count
`endif
);

  localparam int unsigned CntW = $clog2(DRAIN_MAX + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DRAIN_MAX);

  typedef enum logic [1:0] {
    StIdle,
    StDrain,
    StCommit,
    StFlush
  } state_e;

  typedef enum logic [1:0] {
    KindNone,
    KindExc,
    KindIrq,
    KindMret
  } kind_e;

  state_e          r_state;
  state_e          w_state_next;
  kind_e           r_kind;
  kind_e           w_kind_next;
  logic [31:0]     r_cause;
  logic [31:0]     w_cause_next;
  logic [31:0]     r_pc;
  logic [31:0]     w_pc_next;
  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_cnt_next;
  logic [CntW-1:0] w_cnt_inc;
  logic            r_timeout;
  logic            w_timeout_next;
  logic            w_exc_any;
  logic [31:0]     w_exc_cause;

  // Lowest set index wins; ecall cause depends on the privilege sampled this cycle.
  function automatic logic [31:0] f_exc_cause(input logic [3:0] exc, input logic [1:0] priv);
    logic [31:0] cause;
    if (exc[0]) begin
      cause = 32'd0;
    end else if (exc[1]) begin
      cause = 32'd2;
    end else if (exc[2]) begin
      cause = 32'd3;
    end else if (priv == 2'b11) begin
      cause = 32'd11;
    end else begin
      cause = 32'd8;
    end
    return cause;
  endfunction

  assign w_exc_any   = |i_exc_valid;
  assign w_exc_cause = f_exc_cause(i_exc_valid, i_current_privilege);
  assign w_cnt_inc   = r_cnt + {{(CntW-1){1'b0}}, 1'b1};

  always_comb begin
    w_state_next    = r_state;
    w_kind_next     = r_kind;
    w_cause_next    = r_cause;
    w_pc_next       = r_pc;
    w_cnt_next      = r_cnt;
    w_timeout_next  = r_timeout;
    o_trap_valid    = 1'b0;
    o_trap_cause    = 32'd0;
    o_trap_instr_pc = 32'd0;
    o_mret_valid    = 1'b0;
    o_stall         = 1'b0;
    o_flush         = 1'b0;

    case (r_state)
      StIdle: begin
        w_cnt_next = '0;
        if (w_exc_any) begin
          w_kind_next  = KindExc;
          w_cause_next = w_exc_cause;
          w_pc_next    = i_exc_pc;
          w_state_next = StDrain;
        end else if (i_irq_pending) begin
          w_kind_next  = KindIrq;
          w_cause_next = IRQ_CAUSE;
          w_pc_next    = i_current_pc;
          w_state_next = StDrain;
        end else if (i_is_mret) begin
          w_kind_next  = KindMret;
          w_state_next = StDrain;
        end
      end

      StDrain: begin
        o_stall    = 1'b1;
        w_cnt_next = w_cnt_inc;
        // A late exception overrides a pending irq/mret; the drain count keeps running.
        if (w_exc_any && (r_kind != KindExc)) begin
          w_kind_next  = KindExc;
          w_cause_next = w_exc_cause;
          w_pc_next    = i_exc_pc;
        end
        if (!i_pipe_busy) begin
          w_state_next = StCommit;
        end else if (w_cnt_inc == CntMax) begin
          w_state_next   = StCommit;
          w_timeout_next = 1'b1;
        end
      end

      StCommit: begin
        o_stall = 1'b1;
        if (r_kind == KindMret) begin
          o_mret_valid = 1'b1;
        end else begin
          o_trap_valid    = 1'b1;
          o_trap_cause    = r_cause;
          o_trap_instr_pc = r_pc;
        end
        w_state_next = StFlush;
      end

      StFlush: begin
        o_stall      = 1'b1;
        o_flush      = 1'b1;
        w_cnt_next   = '0;
        w_state_next = StIdle;
      end

      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= StIdle;
      r_kind    <= KindNone;
      r_cause   <= 32'd0;
      r_pc      <= 32'd0;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_kind    <= w_kind_next;
      r_cause   <= w_cause_next;
      r_pc      <= w_pc_next;
      r_cnt     <= w_cnt_next;
      r_timeout <= w_timeout_next;
    end
  end

  assign o_drain_timeout = r_timeout;

`ifdef TRAP_SEQ_PERF_EN
  logic [15:0] r_exc_count;
  logic [15:0] r_irq_count;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_exc_count <= 16'd0;
      r_irq_count <= 16'd0;
    end else if (r_state == StCommit) begin
      if ((r_kind == KindExc) && (r_exc_count != 16'hFFFF)) begin
        r_exc_count <= r_exc_count + 16'd1;
      end
      if ((r_kind == KindIrq) && (r_irq_count != 16'hFFFF)) begin
        r_irq_count <= r_irq_count + 16'd1;
      end
    end
  end

  assign o_exc_count = r_exc_count;
  assign o_irq_count = r_irq_count;
`endif

endmodule
